// File: rtl/ram_reader_pkg.sv
// rtl/ram_reader_pkg.sv - shared types and constants for the RAM stream reader
//
// Contents:
//   ram_reader_state_t     sequencer state encoding (IDLE, ISSUE, DRAIN, DONE)
//   RAM_READER_FIFO_DEPTH  output buffer depth (2 entries)
//   RAM_READER_COUNT_BITS  width of the buffer occupancy count
//   RAM_READER_PTR_BITS    width of the buffer read/write pointers

package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ram_reader_state_t;

    localparam int RAM_READER_FIFO_DEPTH = 2;
    localparam int RAM_READER_COUNT_BITS = $clog2(RAM_READER_FIFO_DEPTH + 1);
    localparam int RAM_READER_PTR_BITS   = $clog2(RAM_READER_FIFO_DEPTH);

endpackage

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - valid/ready output stream of the RAM stream reader
//
// Signals:
//   out_data   stream payload (RAM_WIDTH bits)
//   out_valid  payload valid
//   out_ready  consumer ready
//   out_last   final word of the current command
// Modports: master (reader side), slave (consumer side).

interface ram_stream_reader_if #(
    parameter int RAM_WIDTH = 16
) ();

    logic [RAM_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/ram_reader_fifo.sv
// rtl/ram_reader_fifo.sv - 2-entry synchronous FIFO carrying {last, data}
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   push_i         write push_data_i at the next edge
//   push_data_i    entry to write
//   pop_i          drop the head entry at the next edge
//   head_data_o    current head entry (valid when !empty_o)
//   empty_o        no entries held
//   count_o        number of entries held, used for read-issue credit

module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 head_data_o,
    output logic                             empty_o,
    output logic [RAM_READER_COUNT_BITS-1:0] count_o
);

    localparam logic [RAM_READER_COUNT_BITS-1:0] FULL_COUNT =
        RAM_READER_COUNT_BITS'(RAM_READER_FIFO_DEPTH);

    logic [WIDTH-1:0]                 mem_q [RAM_READER_FIFO_DEPTH];
    logic [RAM_READER_PTR_BITS-1:0]   wr_ptr_q;
    logic [RAM_READER_PTR_BITS-1:0]   rd_ptr_q;
    logic [RAM_READER_COUNT_BITS-1:0] count_q;
    logic [RAM_READER_COUNT_BITS-1:0] count_d;
    logic                             do_push;
    logic                             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A simultaneous pop frees the slot being written when full.
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);
    assign count_d = count_q + RAM_READER_COUNT_BITS'(do_push)
                             - RAM_READER_COUNT_BITS'(do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAM_READER_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + RAM_READER_PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + RAM_READER_PTR_BITS'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - reads a run of RAM words and streams them out with valid/ready/last
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             command strobe, sampled only in IDLE
//   base_address      first address of the run (< RAM_DEPTH)
//   length            number of words (0 is legal)
//   stride            address step, present only with RAM_READER_STRIDE_EN
//   busy, done        command in progress / one-cycle completion pulse
//   read_address      RAM read address
//   ram_data          RAM read data, one cycle after the address
//   stream            output stream (ram_stream_reader_if.master)
// Optional feature macro: RAM_READER_STRIDE_EN (adds stride, default step is 1).

module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 10,
    parameter int RAM_DEPTH     = 736
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_address,
    input  logic [RAM_ADDR_BITS-1:0] length,
`ifdef RAM_READER_STRIDE_EN
    input  logic [RAM_ADDR_BITS-1:0] stride,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] read_address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    ram_stream_reader_if.master      stream
);

    localparam logic [RAM_ADDR_BITS-1:0] ONE     = RAM_ADDR_BITS'(1);
    localparam logic [RAM_ADDR_BITS:0]   DEPTH_W = (RAM_ADDR_BITS + 1)'(RAM_DEPTH);

    ram_reader_state_t          state_q, state_d;
    logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [RAM_ADDR_BITS-1:0]   issue_rem_q, issue_rem_d;
    logic [RAM_ADDR_BITS-1:0]   out_rem_q, out_rem_d;
    logic                       inflight_q, inflight_d;
    logic                       inflight_last_q, inflight_last_d;
    logic [RAM_ADDR_BITS-1:0]   step;

`ifdef RAM_READER_STRIDE_EN
    logic [RAM_ADDR_BITS-1:0]   step_q, step_d;
    assign step = step_q;
`else
    assign step = ONE;
`endif

    logic [RAM_READER_COUNT_BITS-1:0] fifo_count;
    logic                             fifo_empty;
    logic [RAM_WIDTH:0]               fifo_head;
    logic                             pop;
    logic                             issue;
    logic [2:0]                       occupancy;
    logic [RAM_ADDR_BITS:0]           addr_sum;
    logic [RAM_ADDR_BITS:0]           addr_sub;
    logic [RAM_ADDR_BITS-1:0]         addr_next;

    ram_reader_fifo #(
        .WIDTH (RAM_WIDTH + 1)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, ram_data}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign pop = !fifo_empty && stream.out_ready;

    // The RAM output register has no enable, so a read may only be issued
    // when the word it returns is guaranteed a FIFO slot next cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == ISSUE) && (occupancy < 3'd2);

    // Wrap modulo RAM_DEPTH with a single conditional subtract; both operands
    // are below RAM_DEPTH so the sum is below 2*RAM_DEPTH.
    assign addr_sum  = {1'b0, addr_q} + {1'b0, step};
    assign addr_sub  = (addr_sum >= DEPTH_W) ? DEPTH_W : '0;
    assign addr_next = RAM_ADDR_BITS'(addr_sum - addr_sub);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        issue_rem_d     = issue_rem_q;
        out_rem_d       = out_rem_q;
`ifdef RAM_READER_STRIDE_EN
        step_d          = step_q;
`endif
        inflight_d      = issue;
        inflight_last_d = issue && (issue_rem_q == ONE);

        if (pop) begin
            out_rem_d = out_rem_q - ONE;
        end
        if (issue) begin
            issue_rem_d = issue_rem_q - ONE;
            // The final address is left on the bus rather than advanced.
            if (issue_rem_q != ONE) begin
                addr_d = addr_next;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    issue_rem_d = length;
                    out_rem_d   = length;
`ifdef RAM_READER_STRIDE_EN
                    step_d      = stride;
`endif
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = base_address;
                    end
                end
            end
            ISSUE: begin
                if (issue && (issue_rem_q == ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (out_rem_q == ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            issue_rem_q     <= '0;
            out_rem_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef RAM_READER_STRIDE_EN
            step_q          <= ONE;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            issue_rem_q     <= issue_rem_d;
            out_rem_q       <= out_rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
`ifdef RAM_READER_STRIDE_EN
            step_q          <= step_d;
`endif
        end
    end

    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign read_address     = addr_q;
    assign stream.out_valid = !fifo_empty;
    assign stream.out_data  = fifo_head[RAM_WIDTH-1:0];
    assign stream.out_last  = !fifo_empty && fifo_head[RAM_WIDTH];

endmodule
